fb_row_writer: RTL

FB_ROW_WRITER -- requirements
Module: fb_row_writer

---
 rtl/fb_row_writer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/fb_row_writer.sv
// ============================================================================
// fb_row_writer
// Line-buffered row writer for a double-buffered 64x64 RGB888 frame memory.
// Pixels are collected in a 64-entry line bank, then copied one column per
// cycle into the back frame. Front/back frames exchange on display vsync.
// Optional feature macro: FB_ROW_WRITER_DOUBLE_BUF_EN (two line banks).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_row_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] fbw_data,
  input  logic [5:0]  fbw_col_addr,
  input  logic        fbw_wren,
  input  logic [5:0]  fbw_row_addr,
  input  logic        fbw_row_store,
  input  logic        fbw_row_swap,
  output logic        fbw_row_rdy,
  input  logic        frame_swap,
  output logic        frame_rdy,
  input  logic        disp_vsync,
  output logic        disp_frame_sel,
  output logic [12:0] fbm_addr,
  output logic [23:0] fbm_data,
  output logic        fbm_we
);

`ifdef FB_ROW_WRITER_DOUBLE_BUF_EN
  localparam int C_AW = 7;
`else
  localparam int C_AW = 6;
`endif
  localparam int C_DEPTH = 1 << C_AW;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_COPY = 1'b1
  } state_t;

  state_t      r_state;
  logic [5:0]  r_col;
  logic [5:0]  r_row;
  logic        r_we;
  logic [12:0] r_addr;
  logic [23:0] r_data;
  logic        r_pend;
  logic        r_frame_rdy;
  logic        r_sel;
  logic [23:0] r_line_mem [0:C_DEPTH-1];

  logic             w_wr_bank;
  logic             w_rd_bank;
  logic [C_AW-1:0]  w_wr_addr;
  logic [C_AW-1:0]  w_rd_addr;
  logic             w_accept;
  logic             w_exchange;

`ifdef FB_ROW_WRITER_DOUBLE_BUF_EN
  logic r_wr_bank;
  logic r_rd_bank;

  assign w_wr_bank = r_wr_bank;
  assign w_rd_bank = r_rd_bank;
  assign w_wr_addr = {w_wr_bank, fbw_col_addr};
  assign w_rd_addr = {w_rd_bank, r_col};

  // Write bank flips on every swap request; a same-cycle store already
  // captured the old bank in the FSM block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank <= 1'b0;
    end else if (fbw_row_swap) begin
      r_wr_bank <= ~r_wr_bank;
    end
  end
`else
  // Single bank: the copy reader leads any writer that starts after the
  // store, so no bank swap is needed and the swap input has no effect.
  logic w_unused_swap;

  assign w_unused_swap = fbw_row_swap;
  assign w_wr_bank     = 1'b0;
  assign w_rd_bank     = 1'b0;
  assign w_wr_addr     = fbw_col_addr;
  assign w_rd_addr     = r_col;
`endif

  // Line bank write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (fbw_wren) begin
      r_line_mem[w_wr_addr] <= fbw_data;
    end
  end

  // Store FSM: read one column per COPY cycle, registered write to frame memory.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_col   <= 6'd0;
      r_row   <= 6'd0;
      r_we    <= 1'b0;
      r_addr  <= 13'd0;
      r_data  <= 24'd0;
`ifdef FB_ROW_WRITER_DOUBLE_BUF_EN
      r_rd_bank <= 1'b0;
`endif
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fbw_row_store) begin
            r_row   <= fbw_row_addr;
            r_col   <= 6'd0;
            r_state <= S_COPY;
`ifdef FB_ROW_WRITER_DOUBLE_BUF_EN
            r_rd_bank <= w_wr_bank;
`endif
          end
        end
        S_COPY: begin
          r_we   <= 1'b1;
          r_addr <= {~r_sel, r_row, r_col};
          r_data <= r_line_mem[w_rd_addr];
          r_col  <= r_col + 6'd1;
          if (r_col == 6'd63) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_accept   = frame_swap & r_frame_rdy;
  assign w_exchange = disp_vsync & r_pend & (r_state == S_IDLE) & ~frame_swap;

  // Frame exchange handshake: accept request, flip front on a quiet vsync,
  // then reopen the back frame one cycle after the flip.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend      <= 1'b0;
      r_frame_rdy <= 1'b1;
      r_sel       <= 1'b0;
    end else if (w_accept) begin
      r_pend      <= 1'b1;
      r_frame_rdy <= 1'b0;
    end else if (w_exchange) begin
      r_pend <= 1'b0;
      r_sel  <= ~r_sel;
    end else if (!r_frame_rdy && !r_pend) begin
      r_frame_rdy <= 1'b1;
    end
  end

  assign fbw_row_rdy    = (r_state == S_IDLE);
  assign frame_rdy      = r_frame_rdy;
  assign disp_frame_sel = r_sel;
  assign fbm_addr       = r_addr;
  assign fbm_data       = r_data;
  assign fbm_we         = r_we;

endmodule

`default_nettype wire
